iter_alu: RTL and testbench
===========================

Name: iter_alu

Overview:
- Parametrised, handshaked RV32/RV64-class integer ALU.
- Single-cycle ops (ADD, SUB, SLT, SLTU, XOR, OR, AND, LUI) produce a registered result one cycle after accept.
- Shifts (SLL, SRL, SRA) run iteratively, SHIFT_STEP bits per cycle, trading area for latency.
- Sits between the decode/issue stage and writeback; valid/ready on both sides.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- SHIFT_STEP, 1, maximum bits shifted per iteration; power of two, 1..XLEN.
- SHAMT_W, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous abort of any in-flight op
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready
- i_op  in  4  opcode, alu_op_e encoding
- i_a  in  XLEN  operand A (rs1; value to shift)
- i_b  in  XLEN  operand B (rs2/imm; shamt = i_b[SHAMT_W-1:0]; LUI value)
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_result  out  XLEN  result
- o_zero  out  1  o_result == 0
- o_illegal  out  1  opcode not in alu_op_e; o_result = 0

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_valid=0, o_result=0, o_zero=1, o_illegal=0. o_ready goes to 1 after reset release.
- States: IDLE, SHIFT, DONE.
- o_ready = (state==IDLE). No accept in SHIFT or DONE. Peak throughput is one op per 2 cycles.
- IDLE, accept, non-shift op or illegal: compute combinationally, register, go DONE. o_valid is high the cycle after accept (latency 1).
- IDLE, accept, shift op with shamt==0: result = i_a, go DONE (latency 1).
- IDLE, accept, shift op with shamt=n>0:
  - load work = i_a, rem = n, latch op; go SHIFT.
  - Each SHIFT cycle: shift work by k = min(rem, SHIFT_STEP); rem -= k.
  - When rem reaches 0 after that cycle's step, go DONE.
  - Latency = 1 + ceil(n / SHIFT_STEP) cycles.
- SRA fills with the latched i_a[XLEN-1] every step. SRL and SLL fill with 0.
- ADD/SUB: modulo 2^XLEN. SUB = a + ~b + 1.
- SLT: signed compare; SLTU: unsigned compare. Result is {XLEN-1 zeros, lt}.
- LUI: result = i_b (caller supplies the pre-shifted immediate).
- DONE: o_valid=1; o_result, o_zero and o_illegal are held stable until the handshake. On o_valid && i_ready go IDLE and drop o_valid next cycle.
- i_flush=1 in any state: next state IDLE, o_valid=0, rem cleared. o_result keeps its value. Flush has priority over a simultaneous accept; a request presented with flush is not accepted.
- i_valid is ignored while o_ready=0. Inputs are sampled only at accept; later changes to i_a, i_b or i_op have no effect.
- Reset asserted mid-shift aborts immediately to reset values.
- SHIFT_STEP=XLEN: every shift completes in one SHIFT cycle (latency 2).

Decomposition:
- alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9, LUI=A; B..F illegal.
  - typedef enum state_e {IDLE, SHIFT, DONE}.
  - helper function is_shift(op).
- Sub-module alu_shift_step:
  - combinational; parameters XLEN, SHIFT_STEP.
  - inputs: work, k, dir, arith.
  - output: shifted work.
  - one instance, used in the SHIFT state.

Test Plan:
- XLEN=32: ADD a=0xFFFF_FFFF, b=1 -> o_result=0, o_zero=1, o_valid one cycle after accept. SUB a=3, b=5 -> 0xFFFF_FFFE.
- SLT a=0xFFFF_FFFF, b=1 -> 1. SLTU with the same operands -> 0. Op 0xC -> o_illegal=1, o_result=0.
- SHIFT_STEP=1: SRA a=0x8000_0000, n=5 -> 0xFC00_0000, o_valid exactly 6 cycles after accept. SRL with the same operands -> 0x0400_0000.
- SHIFT_STEP=4: SLL a=1, n=31 -> 0x8000_0000, latency 9. Shift with n=0 -> a, latency 1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid and o_result stable, o_ready=0, a second i_valid is not accepted. On release, the next op is accepted the cycle after the handshake.
- Flush mid-SHIFT (n=20, step 1, flush at cycle 3) -> IDLE next cycle, no o_valid. Async reset mid-shift -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode/state encodings and opcode helpers shared by the iterative ALU
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLT  = 4'h2,
    ALU_SLTU = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_AND  = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9,
    ALU_LUI  = 4'hA
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  function automatic logic is_shift(input logic [3:0] op);
    return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
  endfunction
  function automatic logic is_legal(input logic [3:0] op);
    return op <= ALU_LUI;
  endfunction
endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: one combinational shift step of up to SHIFT_STEP bits
module alu_shift_step #(
  parameter int XLEN = 32,
  parameter int SHIFT_STEP = 1,
  localparam int KW = $clog2(SHIFT_STEP + 1)
) (
  input  logic [XLEN-1:0] work,
  input  logic [KW-1:0]   k,
  input  logic            dir,
  input  logic            arith,
  output logic [XLEN-1:0] shifted
);
  logic [XLEN-1:0] sra;
  // kept in its own assignment so the arithmetic shift stays signed
  assign sra = $signed(work) >>> k;
  assign shifted = !dir ? work << k : arith ? sra : work >> k;
endmodule

// File: rtl/iter_alu.sv
// iter_alu: handshaked integer ALU, single-cycle logic ops and iterative shifts
module iter_alu import alu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int SHIFT_STEP = 1,
  localparam int SHAMT_W = $clog2(XLEN),
  localparam int KW = $clog2(SHIFT_STEP + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_illegal
);
  state_e state_q, state_d;
  logic [XLEN-1:0] work_q, work_d, res_q, res_d, alu_res, shifted;
  logic [SHAMT_W-1:0] rem_q, rem_d, shamt;
  logic [3:0] op_q, op_d;
  logic ill_q, ill_d, last;
  logic [KW-1:0] k;
  assign shamt = i_b[SHAMT_W-1:0];
  assign last = 32'(rem_q) <= SHIFT_STEP;
  assign k = last ? KW'(rem_q) : KW'(SHIFT_STEP);
  assign o_ready = state_q == IDLE;
  assign o_valid = state_q == DONE;
  assign o_result = res_q;
  assign o_zero = res_q == '0;
  assign o_illegal = ill_q;
  alu_shift_step #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) u_step (
    .work(work_q), .k(k), .dir(op_q != ALU_SLL), .arith(op_q == ALU_SRA), .shifted(shifted)
  );
  // single-cycle result; shifts pass a through for the shamt==0 case
  always_comb begin
    alu_res = '0;
    case (i_op)
      ALU_ADD:  alu_res = i_a + i_b;
      ALU_SUB:  alu_res = i_a + ~i_b + 1'b1;
      ALU_SLT:  alu_res = XLEN'($signed(i_a) < $signed(i_b));
      ALU_SLTU: alu_res = XLEN'(i_a < i_b);
      ALU_XOR:  alu_res = i_a ^ i_b;
      ALU_OR:   alu_res = i_a | i_b;
      ALU_AND:  alu_res = i_a & i_b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = i_a;
      ALU_LUI:  alu_res = i_b;
      default:  alu_res = '0;
    endcase
  end
  // next-state: accept in IDLE, iterate in SHIFT, hold result in DONE; flush wins
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    rem_d = rem_q;
    op_d = op_q;
    res_d = res_q;
    ill_d = ill_q;
    if (i_flush) begin
      state_d = IDLE;
      rem_d = '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          op_d = i_op;
          ill_d = !is_legal(i_op);
          if (is_shift(i_op) && shamt != '0) begin
            work_d = i_a;
            rem_d = shamt;
            state_d = SHIFT;
          end else begin
            res_d = alu_res;
            state_d = DONE;
          end
        end
        SHIFT: begin
          work_d = shifted;
          rem_d = rem_q - SHAMT_W'(k);
          res_d = last ? shifted : res_q;
          state_d = last ? DONE : SHIFT;
        end
        DONE: state_d = i_ready ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  // state and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      work_q <= '0;
      rem_q <= '0;
      op_q <= '0;
      res_q <= '0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      rem_q <= rem_d;
      op_q <= op_d;
      res_q <= res_d;
      ill_q <= ill_d;
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: scoreboard bench for iter_alu with SHIFT_STEP=1 (dut 0) and SHIFT_STEP=4 (dut 1)
module tb_iter_alu;
  import alu_pkg::*;
  typedef struct {
    logic [31:0] r;
    logic z;
    logic il;
    int lat;
    int acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, flush, rdy_dn;
  logic [1:0] v, ordy, ovld, ozero, oill;
  logic [3:0] op;
  logic [31:0] a, b;
  logic [1:0][31:0] res;
  exp_t q[2][$];
  int cyc = 0, total = 0, passed = 0;
  int req_rst = 0, req_idle = 0, req_end = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  iter_alu #(.XLEN(32), .SHIFT_STEP(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v[0]), .o_ready(ordy[0]),
    .i_op(op), .i_a(a), .i_b(b), .o_valid(ovld[0]), .i_ready(rdy_dn),
    .o_result(res[0]), .o_zero(ozero[0]), .o_illegal(oill[0])
  );
  iter_alu #(.XLEN(32), .SHIFT_STEP(4)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .i_valid(v[1]), .o_ready(ordy[1]),
    .i_op(op), .i_a(a), .i_b(b), .o_valid(ovld[1]), .i_ready(rdy_dn),
    .o_result(res[1]), .o_zero(ozero[1]), .o_illegal(oill[1])
  );
  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s dut%0d: got %h, expected %h", nm, d, act, req);
  endtask
  // present a request until accepted, optionally recording the expected response
  task automatic issue(input int d, input logic [3:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] r, input logic il, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    op = o; a = ia; b = ib; v[d] = 1'b1;
    for (int n = 0; !ordy[d]; n++) begin
      if (n > 100) begin
        $display("FAIL accept_timeout dut%0d: got no accept, expected accept within 100 cycles", d);
        $fatal(1, "accept timeout");
      end
      @(negedge clk);
    end
    e.r = r; e.z = (r == 32'h0); e.il = il; e.lat = lat; e.acc = cyc;
    if (push) q[d].push_back(e);
    @(posedge clk);
    #1 v[d] = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
  endtask
  // monitor: compares whatever the DUTs present against the queued expectations
  initial begin
    bit pv[2], hs[2];
    int sr = 0, si = 0, se = 0;
    forever begin
      @(negedge clk);
      if (req_rst != sr) begin
        sr = req_rst;
        for (int d = 0; d < 2; d++) begin
          chk("rst_valid", d, 32'(ovld[d]), 0);
          chk("rst_result", d, res[d], 0);
          chk("rst_zero", d, 32'(ozero[d]), 1);
          chk("rst_illegal", d, 32'(oill[d]), 0);
        end
      end
      if (req_idle != si) begin
        si = req_idle;
        chk("flush_ready", 0, 32'(ordy[0]), 1);
        chk("flush_valid", 0, 32'(ovld[0]), 0);
      end
      if (req_end != se) begin
        se = req_end;
        chk("queue_drained", 0, q[0].size() + q[1].size(), 0);
      end
      for (int d = 0; d < 2; d++) begin
        if (ovld[d]) begin
          if (q[d].size() == 0) chk("unexpected_valid", d, 32'(ovld[d]), 0);
          else begin
            if (!pv[d]) chk("latency", d, cyc - q[d][0].acc, q[d][0].lat);
            chk("result", d, res[d], q[d][0].r);
            chk("busy_ready", d, 32'(ordy[d]), 0);
            if (rdy_dn) begin
              chk("zero", d, 32'(ozero[d]), 32'(q[d][0].z));
              chk("illegal", d, 32'(oill[d]), 32'(q[d][0].il));
              void'(q[d].pop_front());
            end
          end
        end else if (hs[d]) chk("ready_after_handshake", d, 32'(ordy[d]), 1);
        hs[d] = ovld[d] && rdy_dn;
        pv[d] = ovld[d] && !rdy_dn;
      end
    end
  end
  // directed stimulus
  initial begin
    rst_n = 1'b0; flush = 1'b0; rdy_dn = 1'b1; v = '0; op = '0; a = '0; b = '0;
    req_rst++;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(0, ALU_ADD,  32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 1);
    issue(0, ALU_SUB,  32'h3, 32'h5, 32'hFFFF_FFFE, 1'b0, 1, 1);
    issue(0, ALU_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1, 1);
    issue(0, ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 1);
    issue(0, 4'hC,     32'h1234_5678, 32'h1, 32'h0, 1'b1, 1, 1);
    issue(0, ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1, 1);
    issue(0, ALU_OR,   32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1, 1);
    issue(0, ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1, 1);
    issue(0, ALU_LUI,  32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b0, 1, 1);
    issue(0, ALU_SRA,  32'h8000_0000, 32'h5, 32'hFC00_0000, 1'b0, 6, 1);
    issue(0, ALU_SRL,  32'h8000_0000, 32'h5, 32'h0400_0000, 1'b0, 6, 1);
    issue(1, ALU_SLL,  32'h1, 32'd31, 32'h8000_0000, 1'b0, 9, 1);
    issue(1, ALU_SLL,  32'h5, 32'h20, 32'h5, 1'b0, 1, 1);
    issue(1, ALU_SRA,  32'h8000_0000, 32'd6, 32'hFE00_0000, 1'b0, 3, 1);
    issue(1, ALU_SRL,  32'hF000_0000, 32'd4, 32'h0F00_0000, 1'b0, 2, 1);
    rdy_dn = 1'b0;
    issue(0, ALU_ADD, 32'h2, 32'h3, 32'h5, 1'b0, 1, 1);
    fork
      issue(0, ALU_SUB, 32'd10, 32'd4, 32'h6, 1'b0, 1, 1);
      begin
        repeat (5) @(posedge clk);
        #1 rdy_dn = 1'b1;
      end
    join
    issue(0, ALU_SRL, 32'hFFFF_FFFF, 32'd20, 32'h0, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    req_idle++;
    issue(0, ALU_ADD, 32'h7, 32'h1, 32'h8, 1'b0, 1, 1);
    issue(0, ALU_SLL, 32'h1, 32'd20, 32'h0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    req_rst++;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(0, ALU_LUI, 32'h5, 32'h0, 32'h0, 1'b0, 1, 1);
    issue(1, ALU_SRA, 32'h4000_0000, 32'd3, 32'h0800_0000, 1'b0, 2, 1);
    repeat (12) @(negedge clk);
    req_end++;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
